// File: rtl/uart_packet_rx.sv
// Packet framer behind uart_rx: SYNC, LEN, payload, CHK -> buffered valid/ready payload stream.
// Optional saturating statistics counters are enabled with `define UART_PACKET_RX_STATS_EN.
module uart_packet_rx #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid_in,
  output logic [7:0]  data_out,
  output logic        data_valid_out,
  input  logic        data_ready_in,
  output logic        data_last_out,
  output logic [7:0]  pkt_len_out,
  output logic        chk_err_out,
  output logic        timeout_out,
  output logic        drop_out,
  output logic        busy_out
`ifdef UART_PACKET_RX_STATS_EN
  ,
  output logic [15:0] good_cnt_out,
  output logic [15:0] chk_err_cnt_out,
  output logic [15:0] timeout_cnt_out
`endif
);

  localparam int unsigned IDX_W  = $clog2(MAX_LEN + 1);
  localparam int unsigned ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StHunt, StLen, StPayload, StCheck, StDrain} state_e;

  state_e           state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       sum_q, sum_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             chk_err_q, chk_err_d;
  logic             timeout_q, timeout_d;
  logic             drop_q, drop_d;
  logic             wr_en;
  logic             good_evt;
  logic             tmo_run;
  logic             rd_last;
  logic [7:0]       mem_q [MAX_LEN];

  assign tmo_run = (state_q == StLen) || (state_q == StPayload) || (state_q == StCheck);
  assign rd_last = (8'(rd_idx_q) + 8'd1) == len_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    sum_d     = sum_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    tmo_d     = '0;
    chk_err_d = 1'b0;
    timeout_d = 1'b0;
    drop_d    = 1'b0;
    wr_en     = 1'b0;
    good_evt  = 1'b0;

    if (tmo_run) begin
      tmo_d = byte_valid_in ? '0 : tmo_q + TMO_W'(1);
    end

    unique case (state_q)
      StHunt: begin
        if (byte_valid_in && byte_in == SYNC_BYTE) begin
          state_d = StLen;
        end
      end
      StLen: begin
        if (byte_valid_in) begin
          if (byte_in != 8'd0 && byte_in <= MAX_LEN_B) begin
            len_d    = byte_in;
            sum_d    = byte_in;
            wr_idx_d = '0;
            state_d  = StPayload;
          end else begin
            state_d = StHunt;
          end
        end
      end
      StPayload: begin
        if (byte_valid_in) begin
          wr_en    = 1'b1;
          sum_d    = sum_q + byte_in;
          wr_idx_d = wr_idx_q + IDX_W'(1);
          if ((8'(wr_idx_q) + 8'd1) == len_q) begin
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (byte_valid_in) begin
          if (byte_in == sum_q) begin
            rd_idx_d = '0;
            good_evt = 1'b1;
            state_d  = StDrain;
          end else begin
            chk_err_d = 1'b1;
            state_d   = StHunt;
          end
        end
      end
      StDrain: begin
        // The parser stays deaf until the buffer is empty; stray bytes are only reported.
        drop_d = byte_valid_in;
        if (data_ready_in) begin
          if (rd_last) begin
            state_d = StHunt;
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = StHunt;
    endcase

    // A byte landing on the expiry edge loses to the timeout.
    if (tmo_run && tmo_q == TMO_LAST) begin
      state_d   = StHunt;
      timeout_d = 1'b1;
      chk_err_d = 1'b0;
      good_evt  = 1'b0;
      wr_en     = 1'b0;
      tmo_d     = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= StHunt;
      len_q     <= '0;
      sum_q     <= '0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      tmo_q     <= '0;
      chk_err_q <= 1'b0;
      timeout_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      tmo_q     <= tmo_d;
      chk_err_q <= chk_err_d;
      timeout_q <= timeout_d;
      drop_q    <= drop_d;
    end
  end

  // Payload storage carries no reset; it is only read back after being fully written.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem_q[wr_idx_q[ADDR_W-1:0]] <= byte_in;
    end
  end

  assign busy_out       = state_q != StHunt;
  assign data_valid_out = state_q == StDrain;
  assign data_out       = data_valid_out ? mem_q[rd_idx_q[ADDR_W-1:0]] : 8'h00;
  assign data_last_out  = data_valid_out && rd_last;
  assign pkt_len_out    = data_valid_out ? len_q : 8'h00;
  assign chk_err_out    = chk_err_q;
  assign timeout_out    = timeout_q;
  assign drop_out       = drop_q;

`ifdef UART_PACKET_RX_STATS_EN
  logic [15:0] good_cnt_q, chk_err_cnt_q, timeout_cnt_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      good_cnt_q    <= '0;
      chk_err_cnt_q <= '0;
      timeout_cnt_q <= '0;
    end else begin
      if (good_evt && good_cnt_q != 16'hFFFF) begin
        good_cnt_q <= good_cnt_q + 16'd1;
      end
      if (chk_err_d && chk_err_cnt_q != 16'hFFFF) begin
        chk_err_cnt_q <= chk_err_cnt_q + 16'd1;
      end
      if (timeout_d && timeout_cnt_q != 16'hFFFF) begin
        timeout_cnt_q <= timeout_cnt_q + 16'd1;
      end
    end
  end

  assign good_cnt_out    = good_cnt_q;
  assign chk_err_cnt_out = chk_err_cnt_q;
  assign timeout_cnt_out = timeout_cnt_q;
`endif

endmodule
